ps2_key_decoder: RTL

- Upstream stage of the tic-tac-toe controller.
- Receives raw PS/2 keyboard clock and data and deserializes set-2 scancode frames.
- Tracks E0 (extended) and F0 (break) prefixes.
- Drives held-level key signals up/down/left/right/enter/space. The controller synchronizes and edge-detects these levels; this block does not generate pulses for them.

---
 rtl/ps2_key_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver: conditions the raw PS/2 clock/data, deserializes
// frames, tracks E0/F0 prefixes and drives held-level key signals.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic       enter,
   output logic       space,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state;
   logic                  clk_s1, clk_s2;
   logic                  dat_s1, dat_s2;
   logic [FILTER_LEN-1:0] filt_sr;
   logic                  filt_lvl;
   logic                  filt_d;
   logic                  fall;
   logic [7:0]            shift_reg;
   logic                  par_bit;
   logic [2:0]            bit_cnt;
   logic [TW-1:0]         to_cnt;
   logic                  ext;
   logic                  brk;

   // Two-flop synchronizers for the asynchronous PS/2 lines
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s1 <= 1'b0;
         clk_s2 <= 1'b0;
         dat_s1 <= 1'b0;
         dat_s2 <= 1'b0;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // Glitch filter: the filtered clock only changes when every tap agrees
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_sr  <= '1;
         filt_lvl <= 1'b1;
         filt_d   <= 1'b1;
      end else begin
         filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
         if (filt_sr == '0) begin
            filt_lvl <= 1'b0;
         end else if (filt_sr == '1) begin
            filt_lvl <= 1'b1;
         end
         filt_d <= filt_lvl;
      end
   end

   // Single-cycle strobe on a filtered 1->0 transition
   always_comb begin
      fall = filt_d & ~filt_lvl;
   end

   // Frame receiver, timeout supervision, prefix tracking and key decode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         shift_reg  <= '0;
         par_bit    <= 1'b0;
         bit_cnt    <= '0;
         to_cnt     <= '0;
         ext        <= 1'b0;
         brk        <= 1'b0;
         up         <= 1'b0;
         down       <= 1'b0;
         left       <= 1'b0;
         right      <= 1'b0;
         enter      <= 1'b0;
         space      <= 1'b0;
         scan_code  <= '0;
         scan_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         scan_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (state != S_IDLE && !fall) begin
            if (to_cnt == TO_MAX) begin
               state     <= S_IDLE;
               frame_err <= 1'b1;
               ext       <= 1'b0;
               brk       <= 1'b0;
               to_cnt    <= '0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else if (fall) begin
            to_cnt <= '0;
            case (state)
               S_IDLE: begin
                  if (!dat_s2) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               S_DATA: begin
                  shift_reg <= {dat_s2, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= S_PARITY;
                  end
               end
               S_PARITY: begin
                  par_bit <= dat_s2;
                  state   <= S_STOP;
               end
               S_STOP: begin
                  state <= S_IDLE;
                  if ((^{shift_reg, par_bit}) && dat_s2) begin
                     scan_code  <= shift_reg;
                     scan_valid <= 1'b1;
                     if (shift_reg == 8'hE0) begin
                        ext <= 1'b1;
                     end else if (shift_reg == 8'hF0) begin
                        brk <= 1'b1;
                     end else begin
                        case (shift_reg)
                           8'h75: if (ext) up <= !brk;
                           8'h72: if (ext) down <= !brk;
                           8'h6B: if (ext) left <= !brk;
                           8'h74: if (ext) right <= !brk;
                           8'h5A: enter <= !brk;
                           8'h29: if (!ext) space <= !brk;
                           default: ;
                        endcase
                        ext <= 1'b0;
                        brk <= 1'b0;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     ext       <= 1'b0;
                     brk       <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
